// File: rtl/tpu_pkg.sv
// Shared definitions for the TPU datapath blocks: feeder FSM states and
// matrix memory geometry constants.
package tpu_pkg;

  localparam int MATRIX_COUNT     = 4;
  localparam int ELEMS_PER_MATRIX = 4;
  localparam int FEED_CYCLES      = 3;
  localparam int FETCH_CYCLES     = 9;
  localparam int SEL_W            = $clog2(MATRIX_COUNT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_FEED,
    ST_DONE
  } feeder_state_t;

  // Row-major element index, optionally with row/column swapped (transpose).
  function automatic logic [1:0] elem_index(input logic [1:0] idx, input logic swap);
    return swap ? {idx[0], idx[1]} : idx;
  endfunction

endpackage

// File: rtl/matrix_feeder.sv
// matrix_feeder: fetches a 2x2 A and a 2x2 B from the matrix memory into an
// 8-slot buffer, then streams them diagonally skewed into a 2x2 systolic array.
// Optional build macro MATRIX_FEEDER_TRANSPOSE_B_EN adds a transpose_b input
// that fetches B in e0,e2,e1,e3 order so the array receives B transposed.
module matrix_feeder
  import tpu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SEL_W-1:0] mat_a_sel,
  input  logic [SEL_W-1:0] mat_b_sel,
`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
  input  logic             transpose_b,
`endif
  output logic             busy,
  output logic             done,
  output logic             mem_read_en,
  output logic [3:0]       mem_read_addr,
  input  logic [WIDTH-1:0] mem_data,
  output logic             feed_valid,
  output logic [WIDTH-1:0] a_row0,
  output logic [WIDTH-1:0] a_row1,
  output logic [WIDTH-1:0] b_col0,
  output logic [WIDTH-1:0] b_col1
);

  localparam logic [3:0] FETCH_LAST = 4'(FETCH_CYCLES - 1);
  localparam logic [3:0] FEED_LAST  = 4'(FEED_CYCLES - 1);
  localparam logic [3:0] READ_COUNT = 4'(2 * ELEMS_PER_MATRIX);

  feeder_state_t    state, state_next;
  logic [3:0]       cnt, cnt_next;
  logic [SEL_W-1:0] a_sel_q, b_sel_q;
  logic [SEL_W-1:0] a_sel_eff, b_sel_eff;
  logic             xpose_eff;
  logic [3:0]       addr_next;
  logic [2:0]       slot;
  logic [WIDTH-1:0] elem_buf [8];
  logic [WIDTH-1:0] a_row0_n, a_row1_n, b_col0_n, b_col1_n;

  // Selects come straight from the inputs on the accepting edge, latched after.
  assign a_sel_eff = (state == ST_IDLE) ? mat_a_sel : a_sel_q;
  assign b_sel_eff = (state == ST_IDLE) ? mat_b_sel : b_sel_q;
  assign slot      = cnt[2:0] - 3'd1;

`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
  logic xpose_q;

  // Latch the transpose request together with the selects.
  always_ff @(posedge clk) begin
    if (rst)                          xpose_q <= 1'b0;
    else if (state == ST_IDLE && start) xpose_q <= transpose_b;
  end

  assign xpose_eff = (state == ST_IDLE) ? transpose_b : xpose_q;
`else
  assign xpose_eff = 1'b0;
`endif

  // Next-state and counter logic; one counter serves both FETCH and FEED.
  always_comb begin
    // NOTE: defaults first so every path assigns every variable (no latches).
    state_next = state;
    cnt_next   = '0;
    unique case (state)
      ST_IDLE:  if (start) state_next = ST_FETCH;
      ST_FETCH: begin
        if (cnt == FETCH_LAST) state_next = ST_FEED;
        else                   cnt_next   = cnt + 4'd1;
      end
      ST_FEED: begin
        if (cnt == FEED_LAST) state_next = ST_DONE;
        else                  cnt_next   = cnt + 4'd1;
      end
      ST_DONE:  state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  // Address for the read issued in the coming FETCH cycle: A first, then B.
  always_comb begin
    if (!cnt_next[2]) addr_next = {a_sel_eff, cnt_next[1:0]};
    else              addr_next = {b_sel_eff, elem_index(cnt_next[1:0], xpose_eff)};
  end

  // Skewed operand lanes for the coming FEED cycle; unused lanes are zero.
  always_comb begin
    a_row0_n = '0;
    a_row1_n = '0;
    b_col0_n = '0;
    b_col1_n = '0;
    if (state_next == ST_FEED) begin
      unique case (cnt_next[1:0])
        2'd0: begin
          a_row0_n = elem_buf[0];
          b_col0_n = elem_buf[4];
        end
        2'd1: begin
          a_row0_n = elem_buf[1];
          a_row1_n = elem_buf[2];
          b_col0_n = elem_buf[6];
          b_col1_n = elem_buf[5];
        end
        2'd2: begin
          a_row1_n = elem_buf[3];
          b_col1_n = elem_buf[7];
        end
        default: ;
      endcase
    end
  end

  // State, counter, latched selects and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignment only.
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      a_sel_q       <= '0;
      b_sel_q       <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      mem_read_en   <= 1'b0;
      mem_read_addr <= '0;
      feed_valid    <= 1'b0;
      a_row0        <= '0;
      a_row1        <= '0;
      b_col0        <= '0;
      b_col1        <= '0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      if (state == ST_IDLE && start) begin
        a_sel_q <= mat_a_sel;
        b_sel_q <= mat_b_sel;
      end
      busy        <= (state_next == ST_FETCH) || (state_next == ST_FEED);
      done        <= (state_next == ST_DONE);
      mem_read_en <= (state_next == ST_FETCH) && (cnt_next < READ_COUNT);
      if ((state_next == ST_FETCH) && (cnt_next < READ_COUNT))
        mem_read_addr <= addr_next;
      feed_valid  <= (state_next == ST_FEED);
      a_row0      <= a_row0_n;
      a_row1      <= a_row1_n;
      b_col0      <= b_col0_n;
      b_col1      <= b_col1_n;
    end
  end

  // Capture read data one cycle after each read into slot c-1.
  always_ff @(posedge clk) begin
    // NOTE: the buffer is small and must read as zero after reset, so it is cleared.
    if (rst) begin
      for (int i = 0; i < 8; i++) elem_buf[i] <= '0;
    end else if (state == ST_FETCH && cnt != 4'd0) begin
      elem_buf[slot] <= mem_data;
    end
  end

endmodule

// File: tb/tb_matrix_feeder.sv
// Directed self-checking bench for matrix_feeder with a behavioural memory.
module tb_matrix_feeder;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [1:0] mat_a_sel, mat_b_sel;
  logic       transpose_b;
  logic       busy, done, mem_read_en, feed_valid;
  logic [3:0] mem_read_addr;
  logic [7:0] mem_data = '0;
  logic [7:0] a_row0, a_row1, b_col0, b_col1;

  logic [7:0] mem [16];
  int n_checks = 0;
  int n_err    = 0;

  logic [3:0] obs_addr [8];
  logic [7:0] f1 [4];
  logic [7:0] f2 [4];

  always #5 clk = ~clk;

  // Matrix memory: registered read, zero when not enabled.
  always @(posedge clk) mem_data <= mem_read_en ? mem[mem_read_addr] : 8'd0;

  matrix_feeder #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start(start),
    .mat_a_sel(mat_a_sel), .mat_b_sel(mat_b_sel),
`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
    .transpose_b(transpose_b),
`endif
    .busy(busy), .done(done),
    .mem_read_en(mem_read_en), .mem_read_addr(mem_read_addr), .mem_data(mem_data),
    .feed_valid(feed_valid),
    .a_row0(a_row0), .a_row1(a_row1), .b_col0(b_col0), .b_col1(b_col1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " busy"}, busy, 0);
    check({tag, " done"}, done, 0);
    check({tag, " rd_en"}, mem_read_en, 0);
    check({tag, " addr"}, mem_read_addr, 0);
    check({tag, " fv"}, feed_valid, 0);
    check({tag, " lanes"}, {a_row0, a_row1, b_col0, b_col1}, 0);
  endtask

  // One full transaction from start (edge 0) through cycle 15, checked every cycle.
  task automatic run(input logic [1:0] a, input logic [1:0] b, input logic xp,
                     input logic glitch, input string tag);
    logic [3:0] ea [8];
    logic [7:0] am [4];
    logic [7:0] bm [4];
    logic [7:0] el [3][4];
    for (int i = 0; i < 4; i++) begin
      logic [1:0] ii;
      ii = 2'(i);
      ea[i]     = {a, ii};
      ea[4 + i] = {b, xp ? {ii[0], ii[1]} : ii};
      am[i]     = mem[{a, ii}];
    end
    // B as the array sees it: transposed if requested.
    for (int r = 0; r < 2; r++)
      for (int c = 0; c < 2; c++)
        bm[r*2+c] = xp ? mem[{b, 1'(c), 1'(r)}] : mem[{b, 1'(r), 1'(c)}];
    // lanes: a_row0, a_row1, b_col0, b_col1
    el[0] = '{am[0], 8'd0,  bm[0], 8'd0};
    el[1] = '{am[1], am[2], bm[2], bm[1]};
    el[2] = '{8'd0,  am[3], 8'd0,  bm[3]};

    mat_a_sel   = a;
    mat_b_sel   = b;
    transpose_b = xp;
    start       = 1'b1;
    step();
    start       = 1'b0;
    for (int k = 1; k <= 15; k++) begin
      string t;
      t = $sformatf("%s c%0d", tag, k);
      check({t, " busy"}, busy, (k >= 1 && k <= 12) ? 1 : 0);
      check({t, " rd_en"}, mem_read_en, (k <= 8) ? 1 : 0);
      check({t, " addr"}, mem_read_addr, (k <= 8) ? ea[k-1] : ea[7]);
      check({t, " fv"}, feed_valid, (k >= 10 && k <= 12) ? 1 : 0);
      check({t, " done"}, done, (k == 13) ? 1 : 0);
      if (k >= 10 && k <= 12)
        check({t, " lanes"}, {a_row0, a_row1, b_col0, b_col1},
              {el[k-10][0], el[k-10][1], el[k-10][2], el[k-10][3]});
      else
        check({t, " lanes"}, {a_row0, a_row1, b_col0, b_col1}, 0);
      if (k <= 8) obs_addr[k-1] = mem_read_addr;
      if (k == 11) f1 = '{a_row0, a_row1, b_col0, b_col1};
      if (k == 12) f2 = '{a_row0, a_row1, b_col0, b_col1};
      start = glitch && (k == 5 || k == 11 || k == 13);
      if (k < 15) step();
    end
    start = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 8'(i + 1);
    rst = 1'b1; start = 1'b0; mat_a_sel = '0; mat_b_sel = '0; transpose_b = 1'b0;
    step();
    step();
    check_all_zero("reset");
    rst = 1'b0;
    step();
    check_all_zero("idle");

    // A=m0, B=m1
    run(2'd0, 2'd1, 1'b0, 1'b0, "t1");
    for (int i = 0; i < 8; i++) check($sformatf("t1 addr%0d", i), obs_addr[i], i);
    check("t1 f1", {f1[0], f1[1], f1[2], f1[3]}, {8'd2, 8'd3, 8'd7, 8'd6});
    check("t1 f2", {f2[0], f2[1], f2[2], f2[3]}, {8'd0, 8'd4, 8'd0, 8'd8});

    // Same matrix for A and B
    run(2'd2, 2'd2, 1'b0, 1'b0, "t2");
    for (int i = 0; i < 8; i++) check($sformatf("t2 addr%0d", i), obs_addr[i], 8 + (i % 4));
    check("t2 f1", {f1[0], f1[1], f1[2], f1[3]}, {8'd10, 8'd11, 8'd11, 8'd10});

    // start pulsed in cycles 5, 11, 13 must be ignored
    run(2'd0, 2'd1, 1'b0, 1'b1, "t3");

    // Reset in cycle 11 (mid-FEED) aborts with no done
    mat_a_sel = 2'd0; mat_b_sel = 2'd1; transpose_b = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 1; k < 11; k++) step();
    check("t4 c11 fv", feed_valid, 1);
    rst = 1'b1;
    step();
    check_all_zero("t4 c12");
    rst = 1'b0;
    for (int k = 13; k <= 16; k++) begin
      step();
      check($sformatf("t4 c%0d done", k), done, 0);
      check($sformatf("t4 c%0d busy", k), busy, 0);
    end
    run(2'd0, 2'd1, 1'b0, 1'b0, "t5");
    check("t5 f1", {f1[0], f1[1], f1[2], f1[3]}, {8'd2, 8'd3, 8'd7, 8'd6});

`ifdef MATRIX_FEEDER_TRANSPOSE_B_EN
    run(2'd0, 2'd1, 1'b1, 1'b0, "t6");
    check("t6 B addrs", {obs_addr[4], obs_addr[5], obs_addr[6], obs_addr[7]},
          {4'd4, 4'd6, 4'd5, 4'd7});
    check("t6 f1 b", {f1[2], f1[3]}, {8'd6, 8'd7});
    check("t6 f2 b1", f2[3], 8'd8);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
